// File: rtl/fir_pkg.sv
// Shared constants for the FIR core: default geometry, accumulator width and the
// fixed Q1.15 symmetric low-pass coefficient set (sums to 32768, unity DC gain).
package fir_pkg;

   localparam int N         = 16;
   localparam int TAPS      = 8;
   localparam int ACC_W     = 2 * N + $clog2(TAPS);
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 15;

   localparam logic signed [COEF_W-1:0] H_COEF [TAPS] = '{
      -16'sd512, 16'sd0, 16'sd4608, 16'sd12288,
      16'sd12288, 16'sd4608, 16'sd0, -16'sd512
   };

endpackage

// File: rtl/fir_round_sat.sv
// Rounds a Q1.15-scaled accumulator (half toward +inf) and narrows it to N bits.
// Define FIR_SATURATE_EN to clamp out-of-range results; otherwise the low N bits wrap.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int RS_N     = fir_pkg::N,
   parameter int RS_ACC_W = fir_pkg::ACC_W
) (
   input  logic signed [RS_ACC_W-1:0] acc_i,
   output logic signed [RS_N-1:0]     res_o
);

   localparam logic signed [RS_ACC_W-1:0] HALF_LSB =
      RS_ACC_W'(1) <<< (COEF_FRAC - 1);

   logic signed [RS_ACC_W-1:0] rounded;

   assign rounded = (acc_i + HALF_LSB) >>> COEF_FRAC;

`ifdef FIR_SATURATE_EN
   localparam logic signed [RS_ACC_W-1:0] MAX_V =
      {{(RS_ACC_W - RS_N + 1){1'b0}}, {(RS_N - 1){1'b1}}};
   localparam logic signed [RS_ACC_W-1:0] MIN_V =
      {{(RS_ACC_W - RS_N + 1){1'b1}}, {(RS_N - 1){1'b0}}};

   always_comb begin
      res_o = rounded[RS_N-1:0];
      if (rounded > MAX_V) begin
         res_o = MAX_V[RS_N-1:0];
      end else if (rounded < MIN_V) begin
         res_o = MIN_V[RS_N-1:0];
      end
   end
`else
   // Upper bits are deliberately discarded in the wrapping build.
   logic unused_high_bits;
   assign unused_high_bits = ^rounded[RS_ACC_W-1:RS_N];

   always_comb begin
      res_o = rounded[RS_N-1:0];
   end
`endif

endmodule

// File: rtl/fir_filter_core.sv
// Direct-form FIR: TAPS-deep delay line, combinational full-precision MAC, one
// output register. Narrowing behaviour selected by FIR_SATURATE_EN (see fir_round_sat).
module fir_filter_core #(
   parameter int N    = fir_pkg::N,
   parameter int TAPS = fir_pkg::TAPS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [N-1:0] data_in,
   output logic signed [N-1:0] data_out
);
   import fir_pkg::*;

   localparam int AW = 2 * N + $clog2(TAPS);
   localparam int PW = N + COEF_W;

   logic signed [N-1:0]  x_q [TAPS];
   logic signed [N-1:0]  x_d [TAPS];
   logic signed [PW-1:0] prod [TAPS];
   logic signed [AW-1:0] acc;
   logic signed [N-1:0]  data_out_d;
   logic signed [N-1:0]  data_out_q;

   always_comb begin
      x_d[0] = data_in;
      for (int k = 1; k < TAPS; k++) begin
         x_d[k] = x_q[k-1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_mul
         assign prod[gi] = x_q[gi] * H_COEF[gi];
      end
   endgenerate

   // Products are sign-extended to the full accumulator width before summing.
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc = acc + AW'(prod[k]);
      end
   end

   fir_round_sat #(
      .RS_N     (N),
      .RS_ACC_W (AW)
   ) u_round_sat (
      .acc_i (acc),
      .res_o (data_out_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TAPS; k++) begin
            x_q[k] <= '0;
         end
         data_out_q <= '0;
      end else begin
         x_q        <= x_d;
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_fir_filter_core.sv
// Directed bench for fir_filter_core: reset, impulse, DC step, overflow, mid-stream
// reset and full-scale DC; expected overflow value follows FIR_SATURATE_EN.
module tb_fir_filter_core;

   logic               clk;
   logic               reset;
   logic signed [15:0] data_in;
   logic signed [15:0] data_out;

   int checks   = 0;
   int failures = 0;

   fir_filter_core #(.N(16), .TAPS(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then settle 1 time unit so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic signed [15:0] v);
      data_in = v;
      tick();
   endtask

   task automatic check(input string tag, input logic signed [15:0] expv);
      checks++;
      assert (data_out === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, data_out, expv);
      end
      $display("txn %0d %s data_out=%0d expected=%0d", checks, tag, data_out, expv);
   endtask

   logic signed [15:0] imp_exp [9];
   logic signed [15:0] ovf_seq [8];
   logic signed [15:0] ovf_exp;

   initial begin
      imp_exp = '{-16'sd256, 16'sd0, 16'sd2304, 16'sd6144, 16'sd6144,
                  16'sd2304, 16'sd0, -16'sd256, 16'sd0};
      ovf_seq = '{-16'sd32768, -16'sd32768, 16'sd32767, 16'sd32767,
                  16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};
`ifdef FIR_SATURATE_EN
      ovf_exp = 16'sd32767;
`else
      ovf_exp = -16'sd30721;   // 34815 wrapped to 16 bits
`endif

      // Reset held low with a non-zero input.
      reset   = 1'b0;
      data_in = 16'sd1234;
      #1;
      check("reset_initial", 16'sd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("reset_hold", 16'sd0);
      end
      reset = 1'b1;
      // Zero input after release: history must be all zero.
      for (int i = 0; i < 10; i++) begin
         apply(16'sd0);
         check("post_reset_zero", 16'sd0);
      end

      // Impulse response.
      apply(16'sd16384);
      for (int i = 0; i < 9; i++) begin
         apply(16'sd0);
         check("impulse", imp_exp[i]);
      end

      // DC step of 1000.
      for (int i = 0; i < 10; i++) begin
         apply(16'sd1000);
      end
      for (int i = 0; i < 3; i++) begin
         check("dc_1000", 16'sd1000);
         apply(16'sd1000);
      end
      check("dc_1000", 16'sd1000);

      // Overflow pattern from clean history.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply(ovf_seq[i]);
      end
      apply(16'sd0);
      check("overflow_peak", ovf_exp);

      // Mid-stream reset during an impulse response.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      apply(16'sd16384);
      apply(16'sd0);
      check("mid_imp0", -16'sd256);
      apply(16'sd0);
      apply(16'sd0);
      check("mid_imp2", 16'sd2304);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset_async", 16'sd0);
      tick();
      check("mid_reset_hold", 16'sd0);
      reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         apply(16'sd0);
         check("mid_reset_after", 16'sd0);
      end

      // Full-scale DC.
      for (int i = 0; i < 10; i++) begin
         apply(16'sd32767);
      end
      for (int i = 0; i < 3; i++) begin
         check("dc_full_scale", 16'sd32767);
         apply(16'sd32767);
      end
      check("dc_full_scale", 16'sd32767);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_filter_core.md
FIR_FILTER_CORE -- requirements
Module: FIR_filter

Interface
REQ-001 SHALL have parameter N, default 16, sample word width in bits.
REQ-002 SHALL have parameter TAPS, default 8, number of filter taps.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  N  signed two's-complement sample, taken every clock.
REQ-006 SHALL have port data_out  output  N  signed two's-complement filtered sample, registered.

Function
REQ-007 SHALL hold a TAPS-deep delay line x[0..TAPS-1] of N-bit signed samples.
- Each rising edge: x[0] <= data_in; x[k] <= x[k-1].
REQ-008 SHALL use fixed signed Q1.15 coefficients h[0..7] = -512, 0, 4608, 12288, 12288, 4608, 0, -512.
- Sum = 32768, giving unity DC gain.
REQ-009 SHALL compute acc = sum over k of x[k]*h[k] at full precision.
- Accumulator width ACC_W = 2N+clog2(TAPS) = 35 bits, signed; no intermediate truncation.
REQ-010 SHALL scale the result as (acc + 16384) >>> 15, arithmetic shift, rounding half toward +inf.
REQ-011 SHALL register the scaled result into data_out on the edge after the samples reach the delay line.
- A sample captured into x[0] at edge t first affects data_out after edge t+1.
- Fixed latency of 2 edges from data_in to data_out.
REQ-012 SHALL accept a new sample every cycle; there is no handshake, valid or stall.
REQ-013 SHALL narrow the scaled result to N bits as defined in Configuration.

Reset
REQ-014 SHALL, while reset is low, asynchronously clear all delay-line registers and data_out to 0.
REQ-015 SHALL, on reset deassertion, resume at the next rising edge with an all-zero history.
REQ-016 SHALL, if reset is asserted mid-stream, discard all prior history.
- After release, output equals a filter whose input was zero before the first post-reset sample.

Configuration
REQ-017 SHALL support macro FIR_SATURATE_EN.
- Defined: a result above 32767 clamps to 32767; a result below -32768 clamps to -32768.
- Undefined: data_out takes the low N bits of the result, two's-complement wrap.

Structure
REQ-018 SHALL place N, TAPS, ACC_W and the coefficient array in shared package fir_pkg.
REQ-019 SHALL implement rounding and narrowing in one sub-module, fir_round_sat.
- Input: ACC_W-bit accumulator; output: N bits.
- Honours FIR_SATURATE_EN.
REQ-020 SHALL keep the multiply-accumulate combinational in the top level, a single output register stage.
- Target size: 120-400 lines of RTL.

Verification
REQ-021 Reset check: hold reset low with data_in=1234 over several edges -> data_out=0 throughout, delay line all zero.
REQ-022 Impulse: one sample 16384, then zeros -> data_out sequence -256, 0, 2304, 6144, 6144, 2304, 0, -256, then 0.
REQ-023 DC step: constant 1000 -> data_out settles to exactly 1000 within TAPS+2 edges and holds.
REQ-024 Overflow: feed -32768, -32768, 32767, 32767, 32767, 32767, -32768, -32768 (time-reversed to align with h).
- With FIR_SATURATE_EN: peak data_out = 32767.
- Without FIR_SATURATE_EN: peak data_out = wrapped low 16 bits, a negative value.
REQ-025 Mid-stream reset: assert reset during the impulse response.
- data_out is 0 immediately, without waiting for a clock edge.
- After release with zero input, data_out stays 0.
REQ-026 Full-scale DC: constant 32767 -> data_out settles to 32767 with no saturation event, in both build configurations.
